// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the 32/16 divider issue controller.
// Holds the FSM encoding, bypass/timeout result builders and watchdog sizing.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] DBZ_QUOTIENT    = 32'hFFFF_FFFF;
  localparam int          DEFAULT_TIMEOUT = 48;
  localparam int          TIMEOUT_MIN     = 36;
  localparam int          TIMEOUT_MAX     = 255;
  localparam int          WD_W            = 8;

  typedef struct packed {
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        dbz;
    logic        err;
  } result_t;

  // Divide-by-zero never reaches the divider; the low dividend half stands in as remainder.
  function automatic result_t dbz_result(input logic [31:0] dividend);
    result_t r;
    r.quotient  = DBZ_QUOTIENT;
    r.remainder = dividend[15:0];
    r.dbz       = 1'b1;
    r.err       = 1'b0;
    return r;
  endfunction

  function automatic result_t timeout_result();
    result_t r;
    r.quotient  = '0;
    r.remainder = '0;
    r.dbz       = 1'b0;
    r.err       = 1'b1;
    return r;
  endfunction

  function automatic result_t div_result(input logic [31:0] quotient,
                                         input logic [15:0] remainder);
    result_t r;
    r.quotient  = quotient;
    r.remainder = remainder;
    r.dbz       = 1'b0;
    r.err       = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/div_watchdog.sv
// Cycle watchdog for the divider wait phase: counts enabled cycles from zero,
// expire is high during the TIMEOUT-th enabled cycle; clear or reset restart it.
module div_watchdog
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/div32_issue_ctrl.sv
// Issues one 32/16 divide at a time to an iterative divider, bypasses divide-by-zero,
// guards the wait with a watchdog and holds the result until out_ready (no new accept until then).
module div32_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_dividend,
  input  logic [15:0]      in_divisor,
  input  logic [TAG_W-1:0] in_tag,

  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [15:0]      div_divisor,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic [31:0]      div_quotient,
  input  logic [15:0]      div_remainder,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_quotient,
  output logic [15:0]      out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_err
);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        divisor_zero;
  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expire;
  logic [31:0] op_dividend;
  logic [15:0] op_divisor;
  result_t     res;

  assign accept       = in_valid && in_ready;
  assign divisor_zero = (in_divisor == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = divisor_zero ? ST_HOLD : ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      // A result arriving on the expiry cycle still counts as a good result.
      ST_WAIT:  if (div_ready || wd_expire) state_nx = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    wd_enable = 1'b0;
    unique case (state)
      ST_IDLE:  in_ready  = reset && !div_busy;
      ST_ISSUE: div_start = 1'b1;
      ST_WAIT:  wd_enable = 1'b1;
      ST_HOLD:  out_valid = 1'b1;
      default:  ;
    endcase
  end

  assign wd_clear = (state != ST_WAIT);

  div_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Operands stay put from acceptance until the next normal-path acceptance,
  // so the divider sees stable values for the whole ISSUE/WAIT window.
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_dividend <= '0;
      op_divisor  <= '0;
      out_tag     <= '0;
      res         <= '0;
    end else begin
      if (accept) begin
        out_tag <= in_tag;
        if (divisor_zero) begin
          res <= dbz_result(in_dividend);
        end else begin
          op_dividend <= in_dividend;
          op_divisor  <= in_divisor;
        end
      end
      if (state == ST_WAIT) begin
        if (div_ready) begin
          res <= div_result(div_quotient, div_remainder);
        end else if (wd_expire) begin
          res <= timeout_result();
        end
      end
    end
  end

  assign div_dividend  = op_dividend;
  assign div_divisor   = op_divisor;
  assign out_quotient  = res.quotient;
  assign out_remainder = res.remainder;
  assign out_dbz       = res.dbz;
  assign out_err       = res.err;

endmodule

// File: doc/div32_issue_ctrl.md
DIV32_ISSUE_CTRL -- requirements
Module: div32_issue_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the request tag carried alongside the operands.
REQ-002 SHALL have parameter TIMEOUT, default 48: maximum WAIT cycles before the watchdog fires; legal range 36..255.
REQ-003 SHALL have one clock; reset is synchronous and active-low; ports: clock  in  1  rising-edge clock; reset  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  request accepted this cycle when both high.
REQ-005 SHALL have ports: in_dividend  in  32; in_divisor  in  16; in_tag  in  TAG_W.
REQ-006 SHALL have ports: div_start  out  1  one-cycle start pulse to the divider; div_dividend  out  32; div_divisor  out  16.
REQ-007 SHALL have ports: div_busy  in  1  divider busy; div_ready  in  1  divider one-cycle result pulse; div_quotient  in  32; div_remainder  in  16.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1; out_quotient  out  32; out_remainder  out  16; out_tag  out  TAG_W; out_dbz  out  1  divide-by-zero; out_err  out  1  watchdog timeout.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, HOLD.
REQ-010 in_ready SHALL be 1 only in IDLE with div_busy=0; with div_busy=1 in IDLE, in_ready=0.
REQ-011 On acceptance with in_divisor!=0, SHALL register dividend, divisor and tag, and go IDLE->ISSUE.
REQ-012 On acceptance with in_divisor==0, SHALL bypass the divider and go IDLE->HOLD with out_quotient=32'hFFFF_FFFF, out_remainder=in_dividend[15:0], out_dbz=1, out_err=0, and div_start never asserted.
REQ-013 In ISSUE, div_start SHALL be 1 for exactly one cycle while div_dividend/div_divisor carry the registered operands; next state WAIT.
REQ-014 div_dividend/div_divisor SHALL hold the registered operands from ISSUE until leaving WAIT.
REQ-015 In WAIT, when div_ready=1, SHALL capture div_quotient/div_remainder into out_quotient/out_remainder, clear out_dbz/out_err, and go WAIT->HOLD.
REQ-016 In WAIT, the watchdog SHALL count cycles from 0; if it reaches TIMEOUT without div_ready, SHALL go WAIT->HOLD with out_quotient=0, out_remainder=0, out_err=1.
REQ-017 If div_ready and watchdog expiry coincide, div_ready SHALL win (out_err=0).
REQ-018 In HOLD, out_valid SHALL be 1 and all out_* fields SHALL stay stable until out_ready=1; then go HOLD->IDLE.
REQ-019 out_valid SHALL be 0 in IDLE, ISSUE and WAIT; the earliest next acceptance SHALL be the cycle after the HOLD handshake.
REQ-020 div_ready seen in IDLE, ISSUE or HOLD SHALL be ignored.
REQ-021 With the companion 32-iteration divider, out_valid SHALL first be high 34 clocks after the acceptance edge (start sampled at +1, ready pulse during +33..+34, captured at +34).
REQ-022 out_tag SHALL equal the tag accepted with the request, for both the normal and bypass paths.

Reset
REQ-023 reset=0 at a clock edge SHALL force IDLE, watchdog=0, div_start=0, out_valid=0, out_dbz=0, out_err=0, out_quotient=0, out_remainder=0, out_tag=0, div_dividend=0, div_divisor=0.
REQ-024 Reset mid-operation (ISSUE/WAIT/HOLD) SHALL abandon the request silently; a stale div_ready after reset SHALL be ignored per REQ-020.
REQ-025 in_ready SHALL be 0 during any cycle with reset=0.

Structure
REQ-026 Shared package div_ctrl_pkg SHALL hold the state enumeration, DBZ_QUOTIENT=32'hFFFF_FFFF and the default TIMEOUT.
REQ-027 The watchdog SHALL be a sub-module div_watchdog (clear, enable, expire at TIMEOUT); everything else SHALL be in div32_issue_ctrl.

Verification
REQ-028 Bench SHALL cover: dividend 100, divisor 7, tag 3, model divider -> div_start one cycle, out_valid at +34, quotient 14, remainder 2, tag 3, dbz=0, err=0.
REQ-029 Bench SHALL cover: divisor 0, dividend 32'h1234_ABCD -> no div_start, out_valid next cycle, quotient FFFF_FFFF, remainder ABCD, dbz=1.
REQ-030 Bench SHALL cover: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout; handshake -> in_ready=1 next cycle.
REQ-031 Bench SHALL cover: divider stub never pulses div_ready, TIMEOUT=48 -> out_valid 48 cycles after entering WAIT, err=1, quotient=0, remainder=0.
REQ-032 Bench SHALL cover: reset=0 for one cycle during WAIT, then the late div_ready pulse -> state IDLE, out_valid stays 0, the next request completes correctly.
REQ-033 Bench SHALL cover: div_busy=1 in IDLE with in_valid=1 -> in_ready=0, no acceptance until div_busy falls.
